apb_reg_slave: RTL and testbench

- APB3 completer that sits directly downstream of the AXI-to-APB write bridge and consumes its PSEL/PENABLE/PWRITE/PADDR/PWDATA transfers.
- Decodes each transfer into a bank of 32-bit control registers, with programmable wait states, PREADY/PSLVERR response, and read-back.
- Register contents drive the rest of the design through a flattened output bus and per-register write pulses.

---
 rtl/apb_slv_pkg.sv | 47 ++++
 rtl/apb_reg_slave_if.sv | 26 ++
 rtl/apb_reg_bank.sv | 96 +++++++++
 rtl/apb_reg_slave.sv | 141 ++++++++++++++
 tb/tb_apb_reg_slave.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types and helpers for the APB register completer.
// Contents: bus/decode widths, FSM state enum, captured-transfer payload,
//           and the address decode helper (register index + error flag).
package apb_slv_pkg;

  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned IDX_W      = 6;   // up to 64 registers
  localparam int unsigned CNT_W      = 4;   // wait-state counter, 0..15

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             err;
  } dec_t;

  // Transfer captured in the setup phase
  typedef struct packed {
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
    dec_t                  dec;
  } xfer_t;

  // Map a byte address to a register index and flag illegal accesses
  function automatic dec_t decode_addr(
    input logic [APB_ADDR_W-1:0] addr,
    input logic [APB_ADDR_W-1:0] base,
    input int unsigned           num_regs,
    input logic                  is_write
  );
    dec_t                  d;
    logic [APB_ADDR_W-1:0] off;
    off   = addr - base;
    d.idx = off[7:2];
    d.err = (addr[1:0] != 2'b00)
         || (addr < base)
         || (off >= APB_ADDR_W'(num_regs * 4))
         || (is_write && (d.idx == '0));   // register 0 is the read-only ID
    return d;
  endfunction

endpackage

// File: rtl/apb_reg_slave_if.sv
// APB3 bus between a requester (bridge) and the register completer.
// Signals: PSEL/PENABLE/PWRITE/PADDR/PWDATA from requester,
//          PRDATA/PREADY/PSLVERR from completer.
interface apb_reg_slave_if;
  import apb_slv_pkg::*;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [APB_ADDR_W-1:0] PADDR;
  logic [APB_DATA_W-1:0] PWDATA;
  logic [APB_DATA_W-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_reg_bank.sv
// Register storage for the APB completer: write commit, write pulses,
// combinational read mux and, with APB_REG_SLAVE_IRQ_EN, a W1C status
// register in the last slot plus its interrupt output.
// Ports: clk, rst (sync, active high), we/wr_idx/wdata (commit),
//        rd_idx/rd_data_c (read mux), reg_out (flattened contents),
//        wr_pulse (per-register), irq_src/irq (macro APB_REG_SLAVE_IRQ_EN).
module apb_reg_bank
  import apb_slv_pkg::*;
#(
  parameter int unsigned          NUM_REGS = 8,
  parameter logic [APB_DATA_W-1:0] ID_VALUE = 32'hA5B0_0001
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             we,
  input  logic [IDX_W-1:0]                 wr_idx,
  input  logic [APB_DATA_W-1:0]            wdata,
  input  logic [IDX_W-1:0]                 rd_idx,
  output logic [APB_DATA_W-1:0]            rd_data_c,
  output logic [NUM_REGS*APB_DATA_W-1:0]   reg_out,
  output logic [NUM_REGS-1:0]              wr_pulse
`ifdef APB_REG_SLAVE_IRQ_EN
  ,
  input  logic [APB_DATA_W-1:0]            irq_src,
  output logic                             irq
`endif
);

  logic [NUM_REGS-1:0] hit_c;

  // One-hot write enable per register
  always_comb begin
    hit_c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hit_c[i] = we && (wr_idx == IDX_W'(i));
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == 0) begin : g_id
      assign reg_out[APB_DATA_W-1:0] = ID_VALUE;
`ifdef APB_REG_SLAVE_IRQ_EN
    end else if (i == NUM_REGS - 1) begin : g_sts
      logic [APB_DATA_W-1:0] sts_q;
      logic [APB_DATA_W-1:0] clr_c;

      assign clr_c = hit_c[i] ? wdata : '0;

      // Set beats clear on the same bit
      always_ff @(posedge clk) begin
        if (rst) begin
          sts_q <= '0;
          irq   <= 1'b0;
        end else begin
          sts_q <= (sts_q & ~clr_c) | irq_src;
          irq   <= |sts_q;
        end
      end

      assign reg_out[i*APB_DATA_W +: APB_DATA_W] = sts_q;
`endif
    end else begin : g_rw
      logic [APB_DATA_W-1:0] q;

      always_ff @(posedge clk) begin
        if (rst) begin
          q <= '0;
        end else if (hit_c[i]) begin
          q <= wdata;
        end
      end

      assign reg_out[i*APB_DATA_W +: APB_DATA_W] = q;
    end
  end

  // Pulse lines up with the first cycle the new value is visible
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pulse <= '0;
    end else begin
      wr_pulse <= hit_c;
    end
  end

  // Read mux; out-of-range indices return zero
  always_comb begin
    rd_data_c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data_c = reg_out[i*APB_DATA_W +: APB_DATA_W];
      end
    end
  end

endmodule

// File: rtl/apb_reg_slave.sv
// APB3 completer fronting a bank of 32-bit control registers. Handles
// setup/access sequencing, programmable wait states, PSLVERR on illegal
// accesses and read-back. Optional macro: APB_REG_SLAVE_IRQ_EN adds
// irq_src/irq and turns the last register into a W1C status register.
// Ports: clk, rst (sync, active high), apb (slave modport),
//        reg_out (flattened contents), wr_pulse (per-register write pulse),
//        irq_src/irq (macro only).
module apb_reg_slave
  import apb_slv_pkg::*;
#(
  parameter int unsigned           NUM_REGS    = 8,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned           WAIT_STATES = 0,
  parameter logic [APB_DATA_W-1:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                           clk,
  input  logic                           rst,
  apb_reg_slave_if.slave                 apb,
  output logic [NUM_REGS*APB_DATA_W-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
`ifdef APB_REG_SLAVE_IRQ_EN
  ,
  input  logic [APB_DATA_W-1:0]          irq_src,
  output logic                           irq
`endif
);

  apb_state_e            state_q, state_d;
  xfer_t                 xfer_q, xfer_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [APB_DATA_W-1:0] prdata_q, prdata_d;

  dec_t                  dec_bus_c;
  logic [IDX_W-1:0]      rd_idx_c;
  logic [APB_DATA_W-1:0] rd_data_c;
  logic                  commit_c;

  // Decode straight off the bus during setup so a zero-wait response can
  // be loaded at the end of that same cycle
  assign dec_bus_c = decode_addr(apb.PADDR, BASE_ADDR, NUM_REGS, apb.PWRITE);
  assign rd_idx_c  = (state_q == IDLE) ? dec_bus_c.idx : xfer_q.dec.idx;

  // Next-state and response loading
  always_comb begin
    state_d   = state_q;
    xfer_d    = xfer_q;
    cnt_d     = cnt_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    commit_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          xfer_d.write = apb.PWRITE;
          xfer_d.wdata = apb.PWDATA;
          xfer_d.dec   = dec_bus_c;
          if (WAIT_STATES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = dec_bus_c.err;
            prdata_d  = (dec_bus_c.err || apb.PWRITE) ? '0 : rd_data_c;
            state_d   = RESP;
          end else begin
            cnt_d   = CNT_W'(WAIT_STATES);
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (!apb.PSEL) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          pready_d  = 1'b1;
          pslverr_d = xfer_q.dec.err;
          prdata_d  = (xfer_q.dec.err || xfer_q.write) ? '0 : rd_data_c;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        // Only commit if the requester is still in its access phase
        commit_c = apb.PSEL && apb.PENABLE && xfer_q.write && !xfer_q.dec.err;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      xfer_q    <= '0;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      xfer_q    <= xfer_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign apb.PRDATA  = prdata_q;

  apb_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .we        (commit_c),
    .wr_idx    (xfer_q.dec.idx),
    .wdata     (xfer_q.wdata),
    .rd_idx    (rd_idx_c),
    .rd_data_c (rd_data_c),
    .reg_out   (reg_out),
    .wr_pulse  (wr_pulse)
`ifdef APB_REG_SLAVE_IRQ_EN
    ,
    .irq_src   (irq_src),
    .irq       (irq)
`endif
  );

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: one instance with zero wait states
// and one with three, sharing clock/reset and a muxed APB driver.
module tb_apb_reg_slave;
  import apb_slv_pkg::*;

  localparam int unsigned NREGS = 8;
  localparam int unsigned RW    = NREGS * 32;
  localparam logic [31:0] ID    = 32'hA5B0_0001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_reg_slave_if bus0 ();
  apb_reg_slave_if bus3 ();

  logic [RW-1:0]    reg_out0, reg_out3;
  logic [NREGS-1:0] wr_pulse0, wr_pulse3;
`ifdef APB_REG_SLAVE_IRQ_EN
  logic        irq0, irq3;
  logic [31:0] irq_src = '0;
`endif

  // Driver shared by both instances; 'which' selects the target
  logic        which;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;

  assign bus0.PSEL    = psel & ~which;
  assign bus3.PSEL    = psel & which;
  assign bus0.PENABLE = penable;
  assign bus3.PENABLE = penable;
  assign bus0.PWRITE  = pwrite;
  assign bus3.PWRITE  = pwrite;
  assign bus0.PADDR   = paddr;
  assign bus3.PADDR   = paddr;
  assign bus0.PWDATA  = pwdata;
  assign bus3.PWDATA  = pwdata;

  logic             pready_c, pslverr_c;
  logic [31:0]      prdata_c;
  logic [RW-1:0]    ro;
  logic [NREGS-1:0] wp;

  assign pready_c  = which ? bus3.PREADY  : bus0.PREADY;
  assign pslverr_c = which ? bus3.PSLVERR : bus0.PSLVERR;
  assign prdata_c  = which ? bus3.PRDATA  : bus0.PRDATA;
  assign ro        = which ? reg_out3     : reg_out0;
  assign wp        = which ? wr_pulse3    : wr_pulse0;

  apb_reg_slave #(
    .NUM_REGS(NREGS), .BASE_ADDR(32'h0), .WAIT_STATES(0), .ID_VALUE(ID)
  ) u_dut0 (
    .clk(clk), .rst(rst), .apb(bus0.slave),
    .reg_out(reg_out0), .wr_pulse(wr_pulse0)
`ifdef APB_REG_SLAVE_IRQ_EN
    , .irq_src(irq_src), .irq(irq0)
`endif
  );

  apb_reg_slave #(
    .NUM_REGS(NREGS), .BASE_ADDR(32'h0), .WAIT_STATES(3), .ID_VALUE(ID)
  ) u_dut3 (
    .clk(clk), .rst(rst), .apb(bus3.slave),
    .reg_out(reg_out3), .wr_pulse(wr_pulse3)
`ifdef APB_REG_SLAVE_IRQ_EN
    , .irq_src(irq_src), .irq(irq3)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Setup, access until PREADY, then drop PSEL in the cycle after RESP
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic slverr, output int waits,
                          output logic [RW-1:0] ro_rdy);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    tick;
    penable = 1'b1;
    waits   = 0;
    while (!pready_c && waits < 20) begin
      check("prdata_while_wait", prdata_c, 32'h0);
      tick;
      waits++;
    end
    check("pready_seen", 32'(pready_c), 32'h1);
    rdata  = prdata_c;
    slverr = pslverr_c;
    ro_rdy = ro;
    tick;
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [31:0]   rd;
  logic          err;
  int            w;
  logic [RW-1:0] rr;

  logic [31:0] e_addr [3] = '{32'h0000_0000, 32'h0000_0006, 32'h0000_0020};
  logic        e_wr   [3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    which = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; rst = 1'b1;
    tick; tick;
    check("rst_pready",   32'(bus0.PREADY),  32'h0);
    check("rst_pslverr",  32'(bus0.PSLVERR), 32'h0);
    check("rst_prdata",   bus0.PRDATA,       32'h0);
    check("rst_wr_pulse", 32'(wr_pulse0),    32'h0);
    check("rst_reg1",     reg_out0[63:32],   32'h0);
    check("rst_reg0_id",  reg_out0[31:0],    ID);
    rst = 1'b0;
    tick;

    // ID read, zero wait states
    apb_xfer(1'b0, 32'h0, 32'h0, rd, err, w, rr);
    check("id_rdata", rd, ID);
    check("id_err",   32'(err), 32'h0);
    check("id_waits", 32'(w), 32'h0);

    // Write then read register 1
    apb_xfer(1'b1, 32'h4, 32'hDEAD_BEEF, rd, err, w, rr);
    check("w1_err",        32'(err), 32'h0);
    check("w1_not_early",  rr[63:32], 32'h0);
    check("w1_reg_out",    ro[63:32], 32'hDEAD_BEEF);
    check("w1_pulse",      32'(wp), 32'h0000_0002);
    tick;
    check("w1_pulse_once", 32'(wp), 32'h0);
    apb_xfer(1'b0, 32'h4, 32'h0, rd, err, w, rr);
    check("r1_rdata", rd, 32'hDEAD_BEEF);
    check("r1_err",   32'(err), 32'h0);

    // Illegal accesses: ID write, misaligned write, out-of-range read
    for (int i = 0; i < 3; i++) begin
      apb_xfer(e_wr[i], e_addr[i], 32'hFFFF_FFFF, rd, err, w, rr);
      check("err_flag",   32'(err), 32'h1);
      check("err_prdata", rd, 32'h0);
      check("err_pulse",  32'(wp), 32'h0);
      check("err_reg1",   ro[63:32], 32'hDEAD_BEEF);
      check("err_reg0",   ro[31:0], ID);
    end

    // Highest legal address
    apb_xfer(1'b0, 32'h1C, 32'h0, rd, err, w, rr);
    check("last_err",   32'(err), 32'h0);
    check("last_rdata", rd, 32'h0);

    // Bridge-style back-to-back writes
    apb_xfer(1'b1, 32'hC, 32'h1111_1111, rd, err, w, rr);
    check("b2b0_err",   32'(err), 32'h0);
    check("b2b0_pulse", 32'(wp), 32'h0000_0008);
    check("b2b0_reg",   ro[127:96], 32'h1111_1111);
    apb_xfer(1'b1, 32'h10, 32'h2222_2222, rd, err, w, rr);
    check("b2b1_err",   32'(err), 32'h0);
    check("b2b1_waits", 32'(w), 32'h0);
    check("b2b1_pulse", 32'(wp), 32'h0000_0010);
    check("b2b1_reg",   ro[159:128], 32'h2222_2222);
    check("b2b0_keep",  ro[127:96], 32'h1111_1111);
    tick;

    // Three wait states
    which = 1'b1;
    tick;
    apb_xfer(1'b1, 32'h8, 32'h1234_5678, rd, err, w, rr);
    check("ws3_waits",     32'(w), 32'h3);
    check("ws3_err",       32'(err), 32'h0);
    check("ws3_not_early", rr[95:64], 32'h0);
    check("ws3_reg",       ro[95:64], 32'h1234_5678);
    check("ws3_pulse",     32'(wp), 32'h0000_0004);
    apb_xfer(1'b0, 32'h8, 32'h0, rd, err, w, rr);
    check("ws3_rdata",  rd, 32'h1234_5678);
    check("ws3_rwaits", 32'(w), 32'h3);

    // Reset while waiting
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'hCAFE_F00D;
    tick;
    penable = 1'b1;
    check("rstw_pready_a", 32'(pready_c), 32'h0);
    tick;
    check("rstw_pready_b", 32'(pready_c), 32'h0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rstw_pready_c", 32'(pready_c), 32'h0);
    tick;
    check("rstw_pready_d", 32'(pready_c), 32'h0);
    psel = 1'b0; penable = 1'b0;
    tick;
    check("rstw_pready_e", 32'(pready_c), 32'h0);
    check("rstw_reg5",     ro[191:160], 32'h0);
    check("rstw_pulse",    32'(wp), 32'h0);
    check("rstw_reg2_clr", ro[95:64], 32'h0);
    apb_xfer(1'b0, 32'h0, 32'h0, rd, err, w, rr);
    check("rstw_id",    rd, ID);
    check("rstw_err",   32'(err), 32'h0);
    check("rstw_waits", 32'(w), 32'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
